pow_seq: RTL and testbench
==========================

POW_SEQ -- requirements
Module: pow_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 256: base operand width in bits.
REQ-002 The block SHALL take parameter EW, default 8: exponent width in bits, so the exponent range is 0..2^EW-1.
REQ-003 The block SHALL take parameter OW, default 1280: result width in bits; legal values satisfy OW >= WIDTH.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-005 The block SHALL have port i_rstn, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port i_valid, input, 1 bit: the request is valid.
REQ-007 The block SHALL have port o_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port i_a, input, WIDTH bits: base, unsigned.
REQ-009 The block SHALL have port i_e, input, EW bits: exponent, unsigned.
REQ-010 The block SHALL have port o_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port i_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port o_b, output, OW bits: the result a^e mod 2^OW.
REQ-013 The block SHALL have port o_ovf, output, 1 bit: the true a^e is >= 2^OW.
REQ-014 The block SHALL have port o_busy, output, 1 bit: the block is in any state other than IDLE.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, SQR, MUL and DONE; o_ready = (state == IDLE).
REQ-016 Accept rule: a request SHALL be accepted on a rising edge where i_valid && o_ready; i_a and i_e are captured, acc=1, ovf=0, idx=EW-1, next state SQR.
REQ-017 SQR SHALL compute acc <= (acc*acc)[OW-1:0] and set ovf when bits [2*OW-1:OW] of the product are nonzero.
REQ-018 The next state after SQR SHALL be MUL if e[idx]=1; otherwise DONE if idx==0; otherwise SQR with idx <= idx-1.
REQ-019 MUL SHALL compute acc <= (acc*a)[OW-1:0] and set ovf when bits [OW+WIDTH-1:OW] of the product are nonzero.
REQ-020 The next state after MUL SHALL be DONE if idx==0; otherwise SQR with idx <= idx-1.
REQ-021 ovf SHALL be sticky within one operation; it is cleared only on accept or reset.
REQ-022 Latency: o_valid SHALL rise exactly EW + popcount(e) rising edges after the accepting edge; there is no leading-zero skipping.
REQ-023 In DONE, o_valid SHALL be 1 and o_b = acc, o_ovf = ovf.
REQ-024 o_b and o_ovf SHALL hold stable while o_valid && !i_ready.
REQ-025 On an edge with o_valid && i_ready the block SHALL go to IDLE, so o_ready=1 on the next cycle.
REQ-026 The block SHALL NOT accept a new request in the same cycle as the result handshake.
REQ-027 i_valid SHALL be ignored in every state except IDLE; i_a and i_e may change freely after accept.
REQ-028 Outside DONE, o_valid SHALL be 0.
REQ-029 o_b SHALL show the internal accumulator, and o_ovf the internal sticky flag, in all states.
REQ-030 Boundary e=0: the result SHALL be 1 for every a, including 0^0=1, with ovf=0.
REQ-031 Boundary a=0, e>0: the result SHALL be 0 with ovf=0.
REQ-032 Boundary a=1: the result SHALL be 1 with ovf=0 for every e.
REQ-033 Overflow exactness: because every intermediate is a^k with k <= e, o_ovf SHALL equal (a^e >= 2^OW) exactly.
REQ-034 All arithmetic SHALL be unsigned.

Reset
REQ-035 When i_rstn=0 at a rising edge, the block SHALL enter IDLE with acc=0, ovf=0, idx=0 and captured operands=0.
REQ-036 After reset the outputs SHALL be o_valid=0, o_b=0, o_ovf=0, o_busy=0 and o_ready=1.
REQ-037 Reset SHALL take priority over every FSM transition and handshake.
REQ-038 A reset mid-operation SHALL discard the operation with no o_valid pulse.
REQ-039 The block SHALL have no asynchronous reset path; i_rstn is sampled only on i_clk.

Verification (parameters WIDTH=8, EW=4, OW=16)
REQ-040 The bench SHALL cover: a=3, e=5 with i_ready=1 -> o_valid 6 edges after accept, o_b=243, o_ovf=0, then o_ready=1 on the next cycle.
REQ-041 The bench SHALL cover: a=2, e=15 -> latency 8, o_b=32768, o_ovf=0; then a=3, e=15 -> o_b=62059, o_ovf=1.
REQ-042 The bench SHALL cover: a=0, e=0 -> o_b=1, latency 4; and a=0, e=9 -> o_b=0, o_ovf=0.
REQ-043 The bench SHALL cover backpressure: a=5, e=2 with i_ready=0 for 3 cycles after o_valid -> o_valid, o_b=25 and o_ovf held stable, o_ready=0, with i_valid pulses with new operands ignored, then one handshake -> IDLE.
REQ-044 The bench SHALL cover reset mid-operation: accept a=7, e=12, assert i_rstn=0 for 1 edge during SQR -> all outputs at reset values, no o_valid; next request a=2, e=3 -> o_b=8.
REQ-045 The bench SHALL cover back-to-back: requests held on i_valid continuously -> each accepted only in IDLE, results in order, no request lost or duplicated.

Source files
------------

// File: rtl/pow_seq.sv
// Sequential unsigned exponentiation a^e mod 2^OW using MSB-first square-and-multiply.
// Every exponent bit costs one SQR cycle, every set bit one extra MUL cycle.
module pow_seq #(
    parameter int WIDTH = 256,
    parameter int EW    = 8,
    parameter int OW    = 1280
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [EW-1:0]    i_e,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OW-1:0]    o_b,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t               state, state_n;
    logic [OW-1:0]        acc, acc_n;
    logic                 ovf, ovf_n;
    logic [IW-1:0]        idx, idx_n;
    logic [WIDTH-1:0]     a_r, a_n;
    logic [EW-1:0]        e_r, e_n;
    logic [2*OW-1:0]      sq;
    logic [OW+WIDTH-1:0]  mp;

    // Full-width products: the bits above OW feed the sticky overflow flag.
    assign sq = {{OW{1'b0}}, acc} * {{OW{1'b0}}, acc};
    assign mp = {{WIDTH{1'b0}}, acc} * {{OW{1'b0}}, a_r};

    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);
    assign o_valid = (state == DONE);
    assign o_b     = acc;
    assign o_ovf   = ovf;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        ovf_n   = ovf;
        idx_n   = idx;
        a_n     = a_r;
        e_n     = e_r;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    a_n     = i_a;
                    e_n     = i_e;
                    acc_n   = OW'(1);
                    ovf_n   = 1'b0;
                    idx_n   = IW'(EW - 1);
                    state_n = SQR;
                end
            end
            SQR: begin
                acc_n = sq[OW-1:0];
                ovf_n = ovf | (|sq[2*OW-1:OW]);
                if (e_r[idx]) begin
                    state_n = MUL;
                end else if (idx == '0) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx - 1'b1;
                    state_n = SQR;
                end
            end
            MUL: begin
                acc_n = mp[OW-1:0];
                ovf_n = ovf | (|mp[OW+WIDTH-1:OW]);
                if (idx == '0) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx - 1'b1;
                    state_n = SQR;
                end
            end
            DONE: begin
                // Result holds until consumed; a new request waits for IDLE.
                if (i_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            idx   <= '0;
            a_r   <= '0;
            e_r   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ovf   <= ovf_n;
            idx   <= idx_n;
            a_r   <= a_n;
            e_r   <= e_n;
        end
    end

endmodule

// File: tb/tb_pow_seq.sv
// Directed bench for pow_seq at WIDTH=8, EW=4, OW=16 with hand-computed results.
module tb_pow_seq;

    localparam int WIDTH = 8;
    localparam int EW    = 4;
    localparam int OW    = 16;

    logic             i_clk;
    logic             i_rstn;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [EW-1:0]    i_e;
    logic             o_valid;
    logic             i_ready;
    logic [OW-1:0]    o_b;
    logic             o_ovf;
    logic             o_busy;

    int n_checks;
    int n_fail;

    pow_seq #(.WIDTH(WIDTH), .EW(EW), .OW(OW)) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_a    (i_a),
        .i_e    (i_e),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_b    (o_b),
        .o_ovf  (o_ovf),
        .o_busy (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Single-cycle request; returns after the accepting edge.
    task automatic accept(input logic [WIDTH-1:0] a, input logic [EW-1:0] e);
        int guard;
        guard = 0;
        while (!o_ready && guard < 40) begin
            step();
            guard++;
        end
        i_a     = a;
        i_e     = e;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    // Edges from the accepting edge until o_valid; 40 means it never came.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!o_valid && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        step();
        step();
        i_rstn = 1'b1;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        n_checks++; if (o_b !== 16'd0) begin n_fail++; $display("FAIL reset_o_b: got %0d want 0", o_b); end
        n_checks++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_o_ovf: got %b want 0", o_ovf); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_o_busy: got %b want 0", o_busy); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_basic();
        int lat;
        i_ready = 1'b1;
        accept(8'd3, 4'd5);
        n_checks++; if (o_busy !== 1'b1 || o_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got busy=%b ready=%b want 1/0", o_busy, o_ready); end
        n_checks++; if (o_b !== 16'd1 || o_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_acc_init: got %0d/%b want 1/0", o_b, o_ovf); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b want 0", o_valid); end
        wait_valid(lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL basic_latency: got %0d want 6", lat); end
        n_checks++; if (o_b !== 16'd243) begin n_fail++; $display("FAIL basic_o_b: got %0d want 243", o_b); end
        n_checks++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_o_ovf: got %b want 0", o_ovf); end
        step();
        n_checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_return_idle: got ready=%b valid=%b want 1/0", o_ready, o_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] va [7] = '{8'd2, 8'd3, 8'd0, 8'd0, 8'd1, 8'd255, 8'd255};
        logic [EW-1:0]    ve [7] = '{4'd15, 4'd15, 4'd0, 4'd9, 4'd15, 4'd2, 4'd3};
        logic [OW-1:0]    vb [7] = '{16'd32768, 16'd62059, 16'd1, 16'd0, 16'd1, 16'd65025, 16'd767};
        logic             vo [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int               vl [7] = '{8, 8, 4, 6, 8, 5, 6};
        int lat;
        i_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            accept(va[k], ve[k]);
            wait_valid(lat);
            n_checks++; if (lat !== vl[k]) begin n_fail++; $display("FAIL vec%0d_latency: got %0d want %0d", k, lat, vl[k]); end
            n_checks++; if (o_b !== vb[k]) begin n_fail++; $display("FAIL vec%0d_o_b: got %0d want %0d", k, o_b, vb[k]); end
            n_checks++; if (o_ovf !== vo[k]) begin n_fail++; $display("FAIL vec%0d_o_ovf: got %b want %b", k, o_ovf, vo[k]); end
            step();
        end
        i_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        i_ready = 1'b0;
        accept(8'd5, 4'd2);
        wait_valid(lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL bp_latency: got %0d want 5", lat); end
        for (int c = 0; c < 3; c++) begin
            i_valid = 1'b1;
            i_a     = 8'd9 + 8'(c);
            i_e     = 4'd3;
            step();
            n_checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d_hs: got valid=%b ready=%b want 1/0", c, o_valid, o_ready); end
            n_checks++; if (o_b !== 16'd25 || o_ovf !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d_data: got %0d/%b want 25/0", c, o_b, o_ovf); end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        n_checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", o_ready, o_valid); end
        step();
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept: got busy=%b want 0", o_busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        i_ready = 1'b1;
        accept(8'd7, 4'd12);
        step();
        i_rstn = 1'b0;
        step();
        i_rstn = 1'b1;
        n_checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ctrl: got valid=%b busy=%b ready=%b want 0/0/1", o_valid, o_busy, o_ready); end
        n_checks++; if (o_b !== 16'd0 || o_ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_data: got %0d/%b want 0/0", o_b, o_ovf); end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (o_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", seen); end
        accept(8'd2, 4'd3);
        wait_valid(lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL rstmid_next_latency: got %0d want 6", lat); end
        n_checks++; if (o_b !== 16'd8 || o_ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_result: got %0d/%b want 8/0", o_b, o_ovf); end
        step();
        i_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] va [4] = '{8'd3, 8'd2, 8'd5, 8'd1};
        logic [EW-1:0]    ve [4] = '{4'd2, 4'd4, 4'd1, 4'd7};
        logic [OW-1:0]    vb [4] = '{16'd9, 16'd16, 16'd5, 16'd1};
        int               vl [4] = '{5, 5, 5, 7};
        int lat;
        i_ready = 1'b1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_start_ready: got %b want 1", o_ready); end
        i_a     = va[0];
        i_e     = ve[0];
        i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++; if (o_busy !== 1'b1 || o_b !== 16'd1) begin n_fail++; $display("FAIL b2b%0d_accept: got busy=%b b=%0d want 1/1", k, o_busy, o_b); end
            if (k < 3) begin
                i_a = va[k+1];
                i_e = ve[k+1];
            end
            wait_valid(lat);
            n_checks++; if (lat !== vl[k]) begin n_fail++; $display("FAIL b2b%0d_latency: got %0d want %0d", k, lat, vl[k]); end
            n_checks++; if (o_b !== vb[k] || o_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_result: got %0d/%b want %0d/0", k, o_b, o_ovf, vb[k]); end
            step();
            n_checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_idle: got ready=%b valid=%b want 1/0", k, o_ready, o_valid); end
            if (k == 3) i_valid = 1'b0;
        end
        step();
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_extra: got busy=%b want 0", o_busy); end
        i_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_rstn   = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_a      = '0;
        i_e      = '0;
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
